// File: rtl/mm_pkg.sv
// mm_pkg: state encoding, default dimensions and address-width helper shared by the sequencer files
package mm_pkg;
   typedef enum logic [2:0] {IDLE, LOAD_X, MAC, DRAIN, WRITE, DONE} state_t;
   function automatic int aw(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 4;
   localparam int DEF_DEPTH = 4;
   localparam int X_AW = aw(DEF_ROWS * DEF_DEPTH);
   localparam int A_AW = aw(DEF_DEPTH * DEF_COLS);
   localparam int P_AW = aw(DEF_ROWS * DEF_COLS);
endpackage

// File: rtl/mm_addr_gen.sv
// mm_addr_gen: row/col/k loop counters and the derived X, coefficient and result addresses
module mm_addr_gen import mm_pkg::*; #(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int DEPTH = DEF_DEPTH,
   localparam int XW = aw(ROWS * DEPTH),
   localparam int AW = aw(DEPTH * COLS),
   localparam int PW = aw(ROWS * COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          k_inc,
   input  logic          c_inc,
   output logic          k_zero,
   output logic          k_last,
   output logic          elem_last,
   output logic [XW-1:0] x_rd_addr,
   output logic [AW-1:0] rom_addr,
   output logic [PW-1:0] ram_addr
);
   localparam int RW = aw(ROWS);
   localparam int CW = aw(COLS);
   localparam int KW = aw(DEPTH);
   logic [RW-1:0] r;
   logic [CW-1:0] c;
   logic [KW-1:0] k;
   logic r_last, c_last;
   assign k_zero = k == '0;
   assign k_last = k == KW'(DEPTH - 1);
   assign c_last = c == CW'(COLS - 1);
   assign r_last = r == RW'(ROWS - 1);
   assign elem_last = r_last && c_last;
   assign x_rd_addr = XW'(32'(r) * DEPTH + 32'(k));
   assign rom_addr = AW'(32'(k) * COLS + 32'(c));
   assign ram_addr = PW'(32'(r) * COLS + 32'(c));
   // the row counter also wraps so a finished run leaves every index at zero
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r <= '0;
         c <= '0;
         k <= '0;
      end else begin
         if (k_inc) k <= k_last ? '0 : k + 1'b1;
         if (c_inc) begin
            c <= c_last ? '0 : c + 1'b1;
            if (c_last) r <= r_last ? '0 : r + 1'b1;
         end
      end
   end
endmodule

// File: rtl/mm_sequencer.sv
// mm_sequencer: loads X byte-serially, then walks (row, col, k) driving regfile/ROM reads,
// MAC enable/clear and result-RAM writes for P = X*A
module mm_sequencer import mm_pkg::*; #(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int DEPTH = DEF_DEPTH,
   localparam int XW = aw(ROWS * DEPTH),
   localparam int AW = aw(DEPTH * COLS),
   localparam int PW = aw(ROWS * COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_in,
   input  logic          valid_input,
   output logic          x_wr_en,
   output logic [XW-1:0] x_wr_addr,
   output logic [XW-1:0] x_rd_addr,
   output logic          rom_en,
   output logic [AW-1:0] rom_addr,
   output logic          mac_en,
   output logic          mac_clr,
   output logic          ram_we,
   output logic [PW-1:0] ram_addr,
   output logic          busy,
   output logic          finish
);
   state_t state, nxt;
   logic [XW-1:0] n;
   logic n_last, k_zero, k_last, elem_last;
   assign n_last = n == XW'(ROWS * DEPTH - 1);
   mm_addr_gen #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) u_addr (
      .clk       (clk),
      .rst       (rst),
      .clr       (state == IDLE),
      .k_inc     (rom_en),
      .c_inc     (ram_we),
      .k_zero    (k_zero),
      .k_last    (k_last),
      .elem_last (elem_last),
      .x_rd_addr (x_rd_addr),
      .rom_addr  (rom_addr),
      .ram_addr  (ram_addr)
   );
   // the MAC sees each read one cycle later, matching the synchronous regfile/ROM latency
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         n <= '0;
         mac_en <= 1'b0;
         mac_clr <= 1'b0;
      end else begin
         state <= nxt;
         n <= state != LOAD_X ? '0 : valid_input ? (n_last ? '0 : n + 1'b1) : n;
         mac_en <= rom_en;
         mac_clr <= rom_en && k_zero;
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start_in ? LOAD_X : IDLE;
         LOAD_X:  nxt = valid_input && n_last ? MAC : LOAD_X;
         MAC:     nxt = k_last ? DRAIN : MAC;
         DRAIN:   nxt = WRITE;
         WRITE:   nxt = elem_last ? DONE : MAC;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      x_wr_en = state == LOAD_X && valid_input;
      x_wr_addr = n;
      rom_en = state == MAC;
      ram_we = state == WRITE;
      busy = state != IDLE;
      finish = state == DONE;
   end
endmodule
